// File: rtl/mask_key_tally.sv
// Per-bin tally of bright mask pixels inside a horizontal band. At the end of each frame
// it streams one report word per bin and then latches a pressed vector.
// Optional build macro MASK_KEY_TALLY_DEBOUNCE_EN makes a pressed bit also require the previous frame.
module mask_key_tally #(
  parameter int unsigned NUM_KEYS     = 16,
  parameter int unsigned KEY_WIDTH    = 64,
  parameter int unsigned V_TOP        = 300,
  parameter int unsigned V_BOTTOM     = 400,
  parameter int unsigned PRESS_THRESH = 200
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        data_valid_in,
  input  logic                        pixel_data_in,
  input  logic [10:0]                 hcount_in,
  input  logic [9:0]                  vcount_in,
  input  logic                        report_ready_in,
  output logic                        report_valid_out,
  output logic [$clog2(NUM_KEYS)-1:0] key_idx_out,
  output logic [15:0]                 key_count_out,
  output logic                        key_pressed_out,
  output logic [NUM_KEYS-1:0]         pressed_mask_out,
  output logic                        mask_update_out
);

  localparam int unsigned IDX_W     = $clog2(NUM_KEYS);
  localparam int unsigned KEY_SHIFT = $clog2(KEY_WIDTH);
  localparam int unsigned H_LIMIT   = NUM_KEYS * KEY_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

  typedef enum logic [1:0] {ACCUM, REPORT, WAIT_FRAME} state_t;

  state_t             state;
  logic               valid_q;
  logic               pixel_q;
  logic [10:0]        hcount_q;
  logic [9:0]         vcount_q;
  logic [15:0]        counters [NUM_KEYS];
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] over_thresh;
  logic [NUM_KEYS-1:0] pressed_now;
  logic [NUM_KEYS-1:0] mask_next;
  logic [IDX_W-1:0]   hit_bin;
  logic [IDX_W-1:0]   idx_plus;
  logic               hit;
  logic               frame_end;
  logic               frame_start;
  logic               handshake;
`ifdef MASK_KEY_TALLY_DEBOUNCE_EN
  logic [NUM_KEYS-1:0] history;
`endif

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      valid_q  <= 1'b0;
      pixel_q  <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      valid_q  <= data_valid_in;
      pixel_q  <= pixel_data_in;
      hcount_q <= hcount_in;
      vcount_q <= vcount_in;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hit_bin     = IDX_W'(hcount_q >> KEY_SHIFT);
    hit         = valid_q && pixel_q
                  && (32'(vcount_q) >= V_TOP) && (32'(vcount_q) <= V_BOTTOM)
                  && (32'(hcount_q) < H_LIMIT);
    frame_end   = valid_q && (32'(vcount_q) > V_BOTTOM);
    frame_start = valid_q && (32'(vcount_q) < V_TOP);
    handshake   = report_valid_out && report_ready_in;
    idx_plus    = key_idx_out + IDX_W'(1);
    mask_next   = pending;
    mask_next[key_idx_out] = key_pressed_out;
    for (int i = 0; i < NUM_KEYS; i++) begin
      over_thresh[i] = 32'(counters[i]) >= PRESS_THRESH;
    end
`ifdef MASK_KEY_TALLY_DEBOUNCE_EN
    pressed_now = over_thresh & history;
`else
    pressed_now = over_thresh;
`endif
  end

  // The report word is registered; the pending vector collects decisions so the visible mask
  // only changes once the final word is accepted.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state            <= WAIT_FRAME;
      report_valid_out <= 1'b0;
      key_idx_out      <= '0;
      key_count_out    <= '0;
      key_pressed_out  <= 1'b0;
      pressed_mask_out <= '0;
      mask_update_out  <= 1'b0;
      pending          <= '0;
      // NOTE: the counter array is reset explicitly because a fresh frame must start at zero.
      for (int i = 0; i < NUM_KEYS; i++) counters[i] <= '0;
`ifdef MASK_KEY_TALLY_DEBOUNCE_EN
      history          <= '0;
`endif
    end else begin
      mask_update_out <= 1'b0;
      case (state)
        ACCUM: begin
          if (frame_end) begin
            state            <= REPORT;
            report_valid_out <= 1'b1;
            key_idx_out      <= '0;
            key_count_out    <= counters[0];
            key_pressed_out  <= pressed_now[0];
            pending          <= '0;
          end else if (hit && (counters[hit_bin] != 16'hFFFF)) begin
            counters[hit_bin] <= counters[hit_bin] + 16'd1;
          end
        end
        REPORT: begin
          if (handshake) begin
            pending <= mask_next;
            if (key_idx_out == LAST_IDX) begin
              state            <= WAIT_FRAME;
              report_valid_out <= 1'b0;
              pressed_mask_out <= mask_next;
              mask_update_out  <= 1'b1;
              for (int i = 0; i < NUM_KEYS; i++) counters[i] <= '0;
`ifdef MASK_KEY_TALLY_DEBOUNCE_EN
              history          <= over_thresh;
`endif
            end else begin
              key_idx_out     <= idx_plus;
              key_count_out   <= counters[idx_plus];
              key_pressed_out <= pressed_now[idx_plus];
            end
          end
        end
        WAIT_FRAME: begin
          if (frame_start) state <= ACCUM;
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_key_tally.sv
// Directed bench for mask_key_tally: table of frames with hand-computed per-bin results,
// plus a reset-during-report sequence. Honours MASK_KEY_TALLY_DEBOUNCE_EN when defined.
module tb_mask_key_tally;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        data_valid_in;
  logic        pixel_data_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        report_ready_in;
  logic        report_valid_out;
  logic [3:0]  key_idx_out;
  logic [15:0] key_count_out;
  logic        key_pressed_out;
  logic [15:0] pressed_mask_out;
  logic        mask_update_out;

  always #5 clk_in = ~clk_in;

  mask_key_tally dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .data_valid_in    (data_valid_in),
    .pixel_data_in    (pixel_data_in),
    .hcount_in        (hcount_in),
    .vcount_in        (vcount_in),
    .report_ready_in  (report_ready_in),
    .report_valid_out (report_valid_out),
    .key_idx_out      (key_idx_out),
    .key_count_out    (key_count_out),
    .key_pressed_out  (key_pressed_out),
    .pressed_mask_out (pressed_mask_out),
    .mask_update_out  (mask_update_out)
  );

`ifdef MASK_KEY_TALLY_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  // npix pixels laid out row-major: column col + k%width, row row + k/width
  typedef struct {
    string       name;
    int          col;
    int          width;
    int          row;
    int          npix;
    int          exp_bin;
    int          exp_cnt;
    logic [15:0] exp_mask;
    logic [15:0] exp_mask_deb;
    bit          toggle;
  } vec_t;

  vec_t vecs [9];

  int checks = 0;
  int errors = 0;
  int got_n;
  int strobes;
  logic [3:0]  got_idx [16];
  logic [15:0] got_cnt [16];
  logic        got_prs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input bit v, input bit p, input int h, input int vc);
    @(negedge clk_in);
    data_valid_in = v;
    pixel_data_in = p;
    hcount_in     = 11'(h);
    vcount_in     = 10'(vc);
  endtask

  task automatic run_frame(input int col, input int width, input int row, input int npix);
    // in-band pixels before the frame start must be dropped
    for (int k = 0; k < 4; k++) send(1'b1, 1'b1, 0, 350);
    send(1'b1, 1'b0, 0, 0);
    for (int k = 0; k < npix; k++) send(1'b1, 1'b1, col + (k % width), row + (k / width));
    send(1'b1, 1'b1, 0, 401);
    send(1'b0, 1'b0, 0, 0);
  endtask

  task automatic run_report(input bit toggle, input int stop_after);
    logic        hold;
    logic [3:0]  h_idx;
    logic [15:0] h_cnt;
    logic        h_prs;
    int          c;
    got_n   = 0;
    strobes = 0;
    hold    = 1'b0;
    h_idx   = '0;
    h_cnt   = '0;
    h_prs   = 1'b0;
    c       = 0;
    data_valid_in = 1'b1;
    pixel_data_in = 1'b1;
    hcount_in     = 11'd0;
    vcount_in     = 10'd350;
    while (got_n < stop_after && c < 400) begin
      @(negedge clk_in);
      c++;
      if (mask_update_out) strobes++;
      if (hold) begin
        check("hold_valid", 32'(report_valid_out), 32'd1);
        check("hold_idx", 32'(key_idx_out), 32'(h_idx));
        check("hold_cnt", 32'(key_count_out), 32'(h_cnt));
        check("hold_prs", 32'(key_pressed_out), 32'(h_prs));
        hold = 1'b0;
      end
      report_ready_in = 1'b0;
      if (report_valid_out) begin
        if (!toggle || c[0]) begin
          report_ready_in = 1'b1;
          got_idx[got_n] = key_idx_out;
          got_cnt[got_n] = key_count_out;
          got_prs[got_n] = key_pressed_out;
          got_n++;
        end else begin
          hold  = 1'b1;
          h_idx = key_idx_out;
          h_cnt = key_count_out;
          h_prs = key_pressed_out;
        end
      end
    end
  endtask

  task automatic finish_report();
    repeat (3) begin
      @(negedge clk_in);
      report_ready_in = 1'b0;
      if (mask_update_out) strobes++;
    end
    check("valid_done", 32'(report_valid_out), 32'd0);
  endtask

  initial begin
    logic [15:0] exp_mask;
    int          exp_c;

    vecs[0] = '{"bin2_full",   128, 64, 300, 6464,  2, 6464, 16'h0004, 16'h0000, 1'b0};
    vecs[1] = '{"row299",        0, 64, 299,   64,  0,    0, 16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{"col1024",    1024, 24, 300,  240,  0,    0, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{"col1023",    1023,  2, 300,    2, 15,    1, 16'h0000, 16'h0000, 1'b0};
    vecs[4] = '{"row400_tog",   64, 10, 400,   10,  1,   10, 16'h0000, 16'h0000, 1'b1};
    vecs[5] = '{"bin5_199",    320, 64, 300,  199,  5,  199, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{"bin5_200a",   320, 64, 300,  200,  5,  200, 16'h0020, 16'h0000, 1'b0};
    vecs[7] = '{"bin5_200b",   320, 64, 300,  200,  5,  200, 16'h0020, 16'h0020, 1'b0};
    vecs[8] = '{"bin2_again",  128, 64, 300, 6464,  2, 6464, 16'h0004, 16'h0000, 1'b0};

    rst_in          = 1'b0;
    data_valid_in   = 1'b0;
    pixel_data_in   = 1'b0;
    hcount_in       = '0;
    vcount_in       = '0;
    report_ready_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_valid", 32'(report_valid_out), 32'd0);
    check("rst_idx", 32'(key_idx_out), 32'd0);
    check("rst_cnt", 32'(key_count_out), 32'd0);
    check("rst_prs", 32'(key_pressed_out), 32'd0);
    check("rst_mask", 32'(pressed_mask_out), 32'd0);
    check("rst_upd", 32'(mask_update_out), 32'd0);
    rst_in = 1'b1;

    for (int v = 0; v < 9; v++) begin
      run_frame(vecs[v].col, vecs[v].width, vecs[v].row, vecs[v].npix);
      run_report(vecs[v].toggle, 16);
      finish_report();
      exp_mask = DEB ? vecs[v].exp_mask_deb : vecs[v].exp_mask;
      check($sformatf("%s_words", vecs[v].name), 32'(got_n), 32'd16);
      for (int i = 0; i < 16; i++) begin
        if (i < got_n) begin
          exp_c = (i == vecs[v].exp_bin) ? vecs[v].exp_cnt : 0;
          check($sformatf("%s_idx%0d", vecs[v].name, i), 32'(got_idx[i]), 32'(i));
          check($sformatf("%s_cnt%0d", vecs[v].name, i), 32'(got_cnt[i]), 32'(exp_c));
          check($sformatf("%s_prs%0d", vecs[v].name, i), 32'(got_prs[i]), 32'(exp_mask[i]));
        end
      end
      check($sformatf("%s_mask", vecs[v].name), 32'(pressed_mask_out), 32'(exp_mask));
      check($sformatf("%s_strobe", vecs[v].name), 32'(strobes), 32'd1);
    end

    // reset after word 7 is accepted: report aborts, no strobe, mask cleared
    run_frame(192, 64, 300, 250);
    run_report(1'b0, 8);
    check("abort_words", 32'(got_n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_n) check($sformatf("abort_idx%0d", i), 32'(got_idx[i]), 32'(i));
    end
    @(negedge clk_in);
    rst_in          = 1'b0;
    report_ready_in = 1'b0;
    data_valid_in   = 1'b0;
    if (mask_update_out) strobes++;
    @(negedge clk_in);
    if (mask_update_out) strobes++;
    check("abort_valid", 32'(report_valid_out), 32'd0);
    check("abort_mask", 32'(pressed_mask_out), 32'd0);
    check("abort_idx", 32'(key_idx_out), 32'd0);
    check("abort_cnt", 32'(key_count_out), 32'd0);
    rst_in = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      if (mask_update_out) strobes++;
    end
    check("abort_strobe", 32'(strobes), 32'd0);

    run_frame(192, 64, 300, 250);
    run_report(1'b0, 16);
    finish_report();
    exp_mask = DEB ? 16'h0000 : 16'h0008;
    check("clean_words", 32'(got_n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < got_n) begin
        exp_c = (i == 3) ? 250 : 0;
        check($sformatf("clean_idx%0d", i), 32'(got_idx[i]), 32'(i));
        check($sformatf("clean_cnt%0d", i), 32'(got_cnt[i]), 32'(exp_c));
      end
    end
    check("clean_mask", 32'(pressed_mask_out), 32'(exp_mask));
    check("clean_strobe", 32'(strobes), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
